// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program-counter / fetch-address generator.
// Supports sequential, backward, skip, signed relative, absolute jump,
// call/return and a sticky halt/resume state machine.
// Optional feature macro: FETCH_RAS_EN enables the return-address stack,
// RasCount and the sticky overflow/underflow flags.
module fetch_pc_unit #(
    parameter int unsigned           PC_WIDTH  = 8,
    parameter int unsigned           OFF_WIDTH = 6,
    parameter int unsigned           RAS_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0
) (
    input  logic                             CLK,
    input  logic                             Init,
    input  logic                             Halt,
    input  logic                             Resume,
    input  logic                             Stall,
    input  logic [2:0]                       Mode,
    input  logic [PC_WIDTH-1:0]              Target,
    input  logic [OFF_WIDTH-1:0]             Offset,
    output logic [PC_WIDTH-1:0]              PC,
    output logic                             Halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   RasCount,
    output logic                             RasOverflow,
    output logic                             RasUnderflow
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_HALTED = 1'b1;

    localparam logic [2:0] M_SEQ  = 3'd0;
    localparam logic [2:0] M_BACK = 3'd1;
    localparam logic [2:0] M_SKIP = 3'd2;
    localparam logic [2:0] M_REL  = 3'd3;
    localparam logic [2:0] M_JMP  = 3'd4;
    localparam logic [2:0] M_CALL = 3'd5;
    localparam logic [2:0] M_RET  = 3'd6;

    logic                state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] off_ext;
    logic                advance;

`ifdef FETCH_RAS_EN
    localparam int unsigned AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [CW-1:0]       ras_cnt;
    logic                ras_ovf;
    logic                ras_unf;
    logic                ras_full;
    logic                ras_empty;
    logic [PC_WIDTH-1:0] ras_top;
    logic                do_push;
    logic                do_pop;
    logic                set_ovf;
    logic                set_unf;

    assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));
    assign ras_empty = (ras_cnt == '0);
    assign ras_top   = ras_mem[AW'(ras_cnt - 1'b1)];
`endif

    assign pc_seq  = pc_q + 1'b1;
    assign off_ext = PC_WIDTH'(signed'(Offset));
    // Mode only takes effect when running, not halting and not stalled
    assign advance = (state_q == ST_RUN) && !Halt && !Stall;

    // Next-PC selection and stack operation decode
    always_comb begin
        pc_next = pc_seq;
`ifdef FETCH_RAS_EN
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
`endif
        case (Mode)
            M_SEQ:  pc_next = pc_seq;
            M_BACK: pc_next = pc_q - 1'b1;
            M_SKIP: pc_next = pc_q + PC_WIDTH'(2);
            M_REL:  pc_next = pc_q + off_ext;
            M_JMP:  pc_next = Target;
            M_CALL: begin
                pc_next = Target;
`ifdef FETCH_RAS_EN
                if (ras_full) set_ovf = advance;
                else          do_push = advance;
`endif
            end
            M_RET: begin
`ifdef FETCH_RAS_EN
                if (ras_empty) begin
                    pc_next = pc_seq;
                    set_unf = advance;
                end else begin
                    pc_next = ras_top;
                    do_pop  = advance;
                end
`else
                pc_next = pc_seq;
`endif
            end
            default: pc_next = pc_seq;
        endcase
    end

    // PC and run/halt state machine
    always_ff @(posedge CLK) begin
        if (Init) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (Halt)        state_q <= ST_HALTED;
                    else if (!Stall) pc_q    <= pc_next;
                end
                default: begin
                    if (Resume && !Halt) state_q <= ST_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_RAS_EN
    // Stack occupancy and sticky error flags
    always_ff @(posedge CLK) begin
        if (Init) begin
            ras_cnt <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            if (do_push)      ras_cnt <= ras_cnt + 1'b1;
            else if (do_pop)  ras_cnt <= ras_cnt - 1'b1;
            if (set_ovf) ras_ovf <= 1'b1;
            if (set_unf) ras_unf <= 1'b1;
        end
    end

    // Stack storage; contents are don't-care after Init so no reset
    always_ff @(posedge CLK) begin
        if (!Init && do_push) ras_mem[AW'(ras_cnt)] <= pc_seq;
    end

    assign RasCount     = ras_cnt;
    assign RasOverflow  = ras_ovf;
    assign RasUnderflow = ras_unf;
`else
    assign RasCount     = '0;
    assign RasOverflow  = 1'b0;
    assign RasUnderflow = 1'b0;
`endif

    assign PC     = pc_q;
    assign Halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed scenarios plus randomized stimulus
// checked against a behavioural model (PC arithmetic mod 256, stack as queue).
// Honours FETCH_RAS_EN the same way as the design.
module tb_fetch_pc_unit;

    localparam int PCW   = 8;
    localparam int OFFW  = 6;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            CLK = 1'b0;
    logic            Init = 1'b0, Halt = 1'b0, Resume = 1'b0, Stall = 1'b0;
    logic [2:0]      Mode = 3'd0;
    logic [PCW-1:0]  Target = '0;
    logic [OFFW-1:0] Offset = '0;
    logic [PCW-1:0]  PC;
    logic            Halted;
    logic [CW-1:0]   RasCount;
    logic            RasOverflow, RasUnderflow;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef FETCH_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    // behavioural model state
    int m_pc;
    bit m_halted;
    int m_stack[$];
    bit m_ovf, m_unf;

    fetch_pc_unit #(
        .PC_WIDTH (PCW),
        .OFF_WIDTH(OFFW),
        .RAS_DEPTH(DEPTH),
        .RESET_PC (8'd0)
    ) dut (
        .CLK(CLK), .Init(Init), .Halt(Halt), .Resume(Resume), .Stall(Stall),
        .Mode(Mode), .Target(Target), .Offset(Offset), .PC(PC),
        .Halted(Halted), .RasCount(RasCount), .RasOverflow(RasOverflow),
        .RasUnderflow(RasUnderflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_step(bit i, bit h, bit r, bit s, int md, int tg, int off);
        int soff;
        soff = (off >= 32) ? off - 64 : off;
        if (i) begin
            m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
        end else if (m_halted) begin
            if (r && !h) m_halted = 0;
        end else if (h) begin
            m_halted = 1;
        end else if (!s) begin
            case (md)
                1: m_pc = m_pc - 1;
                2: m_pc = m_pc + 2;
                3: m_pc = m_pc + soff;
                4: m_pc = tg;
                5: begin
                    if (RAS) begin
                        if (m_stack.size() == DEPTH) m_ovf = 1;
                        else m_stack.push_back((m_pc + 1) % 256);
                    end
                    m_pc = tg;
                end
                6: begin
                    if (RAS && m_stack.size() > 0) m_pc = m_stack.pop_back();
                    else begin
                        m_pc = m_pc + 1;
                        if (RAS) m_unf = 1;
                    end
                end
                default: m_pc = m_pc + 1;
            endcase
            m_pc = ((m_pc % 256) + 256) % 256;
        end
    endfunction

    // apply one cycle of inputs, update the model at the edge, settle
    task automatic drive(bit i, bit h, bit r, bit s, int md, int tg, int off);
        Init = i; Halt = h; Resume = r; Stall = s;
        Mode = md[2:0]; Target = tg[PCW-1:0]; Offset = off[OFFW-1:0];
        @(posedge CLK);
        model_step(i, h, r, s, md, tg, off);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (PC !== 8'd0 || Halted !== 1'b0 || RasCount !== '0 ||
            RasOverflow !== 1'b0 || RasUnderflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: PC=%0d Halted=%b Cnt=%0d Ovf=%b Unf=%b required 0,0,0,0,0",
                     PC, Halted, RasCount, RasOverflow, RasUnderflow);
        end
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            n_tests++;
            if (PC !== PCW'(k)) begin
                n_fail++;
                $display("FAIL seq_after_reset: PC=%0d required %0d", PC, k);
            end
        end
    endtask

    task automatic test_wrap();
        int md[4]  = '{0, 1, 2, 3};
        int pre[4] = '{255, 0, 254, 2};
        int exp[4] = '{0, 255, 0, 253};
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 4, pre[k], 0);
            drive(0, 0, 0, 0, md[k], 0, 6'b111011);
            n_tests++;
            if (PC !== PCW'(exp[k])) begin
                n_fail++;
                $display("FAIL wrap mode %0d from %0d: PC=%0d required %0d", md[k], pre[k], PC, exp[k]);
            end
        end
    endtask

    task automatic test_rel_jmp();
        drive(0, 0, 0, 0, 4, 10, 0);
        drive(0, 0, 0, 0, 3, 0, 6'b111100);
        n_tests++;
        if (PC !== 8'd6) begin
            n_fail++; $display("FAIL rel_neg4: PC=%0d required 6", PC);
        end
        drive(0, 0, 0, 0, 4, 8'h80, 0);
        n_tests++;
        if (PC !== 8'h80) begin
            n_fail++; $display("FAIL jmp: PC=%0h required 80", PC);
        end
        drive(0, 0, 0, 1, 4, 8'h11, 0);
        n_tests++;
        if (PC !== 8'h80) begin
            n_fail++; $display("FAIL stall: PC=%0h required 80", PC);
        end
    endtask

    task automatic test_halt();
        drive(0, 0, 0, 0, 4, 5, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (PC !== 8'd5 || Halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halted_hold %0d: PC=%0d Halted=%b required 5,1", k, PC, Halted);
            end
            drive(0, 0, 0, 0, 0, 0, 0);
        end
        drive(0, 1, 1, 0, 0, 0, 0);
        n_tests++;
        if (Halted !== 1'b1 || PC !== 8'd5) begin
            n_fail++; $display("FAIL halt_and_resume: Halted=%b PC=%0d required 1,5", Halted, PC);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        n_tests++;
        if (Halted !== 1'b0 || PC !== 8'd5) begin
            n_fail++; $display("FAIL resume_edge: Halted=%b PC=%0d required 0,5", Halted, PC);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (PC !== 8'd6) begin
            n_fail++; $display("FAIL after_resume: PC=%0d required 6", PC);
        end
    endtask

    task automatic test_stack();
        int exp_pc;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 4, 1, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 5, 10 * (k + 1), 0);
            n_tests++;
            if (PC !== PCW'(10 * (k + 1)) || RasCount !== CW'(RAS ? ((k < 4) ? k + 1 : 4) : 0)) begin
                n_fail++;
                $display("FAIL call %0d: PC=%0d Cnt=%0d required %0d,%0d", k, PC, RasCount,
                         10 * (k + 1), RAS ? ((k < 4) ? k + 1 : 4) : 0);
            end
            if (k < 4) drive(0, 0, 0, 0, 0, 0, 0);
        end
        n_tests++;
        if (RasOverflow !== RAS || RasUnderflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_flag: Ovf=%b Unf=%b required %b,0", RasOverflow, RasUnderflow, RAS);
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 6, 0, 0);
            exp_pc = RAS ? ((k < 4) ? 32 - 10 * k : 3) : 51 + k;
            n_tests++;
            if (PC !== PCW'(exp_pc)) begin
                n_fail++; $display("FAIL ret %0d: PC=%0d required %0d", k, PC, exp_pc);
            end
        end
        n_tests++;
        if (RasUnderflow !== RAS || RasOverflow !== RAS || RasCount !== '0) begin
            n_fail++;
            $display("FAIL underflow_flag: Unf=%b Ovf=%b Cnt=%0d required %b,%b,0",
                     RasUnderflow, RasOverflow, RasCount, RAS, RAS);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (PC !== 8'd0 || RasCount !== '0 || RasOverflow !== 1'b0 || RasUnderflow !== 1'b0) begin
            n_fail++;
            $display("FAIL init_after_stack: PC=%0d Cnt=%0d Ovf=%b Unf=%b required 0,0,0,0",
                     PC, RasCount, RasOverflow, RasUnderflow);
        end
    endtask

    task automatic test_init_midop();
        drive(0, 0, 0, 0, 5, 40, 0);
        drive(0, 0, 0, 0, 5, 60, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 5, 7, 0);
        n_tests++;
        if (PC !== 8'd0 || Halted !== 1'b0 || RasCount !== '0) begin
            n_fail++;
            $display("FAIL init_midop: PC=%0d Halted=%b Cnt=%0d required 0,0,0", PC, Halted, RasCount);
        end
    endtask

    task automatic test_random();
        bit i, h, r, s;
        int md, tg, off;
        for (int k = 0; k < 600; k++) begin
            i   = ($urandom_range(0, 63) == 0);
            h   = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 3) == 0);
            s   = ($urandom_range(0, 7) == 0);
            md  = $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0) md = 5 + $urandom_range(0, 1);
            tg  = $urandom_range(0, 255);
            off = $urandom_range(0, 63);
            drive(i, h, r, s, md, tg, off);
            n_tests++;
            if (PC !== PCW'(m_pc) || Halted !== m_halted || RasCount !== CW'(m_stack.size()) ||
                RasOverflow !== m_ovf || RasUnderflow !== m_unf) begin
                n_fail++;
                $display("FAIL random cycle %0d: PC=%0d H=%b C=%0d O=%b U=%b required %0d,%b,%0d,%b,%b",
                         k, PC, Halted, RasCount, RasOverflow, RasUnderflow,
                         m_pc, m_halted, m_stack.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
        #1;
        test_reset();
        test_wrap();
        test_rel_jmp();
        test_halt();
        test_stack();
        test_init_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
